// File: rtl/ram_lsu_ctrl_pkg.sv
// Shared definitions for the load/store controller: access size codes,
// the zero word and the access legality check.
package ram_lsu_ctrl_pkg;

    typedef enum logic [1:0] {
        LSU_SIZE_B = 2'b00,
        LSU_SIZE_H = 2'b01,
        LSU_SIZE_W = 2'b10,
        LSU_SIZE_X = 2'b11
    } lsu_size_e;

    localparam logic [31:0] ZERO_WORD = '0;

    // Illegal size, misaligned half/word, or word index beyond the RAM.
    function automatic logic lsu_access_err(input lsu_size_e   size,
                                            input logic [31:0] addr,
                                            input int unsigned depth);
        logic bad_align;
        case (size)
            LSU_SIZE_B: bad_align = 1'b0;
            LSU_SIZE_H: bad_align = addr[0];
            LSU_SIZE_W: bad_align = |addr[1:0];
            default:    bad_align = 1'b1;
        endcase
        return bad_align || ({2'b00, addr[31:2]} >= 32'(depth));
    endfunction

endpackage

// File: rtl/ram_lsu_ctrl_if.sv
// Core-side request/completion bus of the load/store controller.
interface ram_lsu_ctrl_if;

    logic        req_i;
    logic        ready_o;
    logic        we_i;
    logic [1:0]  size_i;
    logic        unsigned_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        done_o;
    logic [31:0] rdata_o;
    logic        err_o;

    modport master (
        output req_i, we_i, size_i, unsigned_i, addr_i, wdata_i,
        input  ready_o, done_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, we_i, size_i, unsigned_i, addr_i, wdata_i,
        output ready_o, done_o, rdata_o, err_o
    );

endinterface

// File: rtl/ram_lsu_ctrl_lane_align.sv
// Little-endian lane handling: extracts/extends load data from a RAM word and
// merges sub-word store data into a RAM word.
module lsu_lane_align
    import ram_lsu_ctrl_pkg::*;
(
    input  logic [31:0] ram_word,
    input  logic [31:0] wdata,
    input  lsu_size_e   size,
    input  logic [1:0]  lane,
    input  logic        is_unsigned,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = ram_word[{lane, 3'b000} +: 8];
        half_sel = ram_word[{lane[1], 4'b0000} +: 16];

        load_data = ram_word;
        case (size)
            LSU_SIZE_B: load_data = {{24{byte_sel[7] & ~is_unsigned}}, byte_sel};
            LSU_SIZE_H: load_data = {{16{half_sel[15] & ~is_unsigned}}, half_sel};
            default:    ;
        endcase

        merge_data = ram_word;
        case (size)
            LSU_SIZE_B: merge_data[{lane, 3'b000} +: 8]     = wdata[7:0];
            LSU_SIZE_H: merge_data[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            default:    merge_data = wdata;
        endcase
    end

endmodule

// File: rtl/ram_lsu_ctrl.sv
// Load/store controller between the memory-access stage and a word-wide RAM
// with combinational read; sub-word stores are done as read-modify-write.
module ram_lsu_ctrl
    import ram_lsu_ctrl_pkg::*;
#(
    parameter int unsigned RAM_DEPTH = 4096
) (
    input  logic            clk,
    input  logic            rst,
    ram_lsu_ctrl_if.slave   bus,
    output logic [31:0]     ram_addr_o,
    output logic [31:0]     ram_wdata_o,
    output logic            ram_wr_en_o,
    input  logic [31:0]     ram_rdata_i
);

    typedef enum logic [2:0] {
        S_IDLE, S_ERR, S_LOAD, S_RMW_RD, S_STORE_W, S_WRITE
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, wdata_q, merge_q;
    lsu_size_e   size_q;
    logic        we_q, unsigned_q;
    logic        done_q, err_q;
    logic [31:0] rdata_q;
    logic        accept, acc_err;
    logic [31:0] load_data, merge_data;

    assign bus.ready_o = (state_q == S_IDLE) && !rst;
    assign accept      = bus.req_i && bus.ready_o;
    assign acc_err     = lsu_access_err(lsu_size_e'(bus.size_i), bus.addr_i, RAM_DEPTH);

    assign bus.done_o  = done_q;
    assign bus.err_o   = err_q;
    assign bus.rdata_o = rdata_q;

    lsu_lane_align u_align (
        .ram_word    (ram_rdata_i),
        .wdata       (wdata_q),
        .size        (size_q),
        .lane        (addr_q[1:0]),
        .is_unsigned (unsigned_q),
        .load_data   (load_data),
        .merge_data  (merge_data)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        ram_addr_o  = ZERO_WORD;
        ram_wdata_o = ZERO_WORD;
        ram_wr_en_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (acc_err)                                   state_d = S_ERR;
                    else if (!bus.we_i)                            state_d = S_LOAD;
                    else if (lsu_size_e'(bus.size_i) == LSU_SIZE_W) state_d = S_STORE_W;
                    else                                           state_d = S_RMW_RD;
                end
            end
            S_ERR:    state_d = S_IDLE;
            S_LOAD: begin
                ram_addr_o = addr_q;
                state_d    = S_IDLE;
            end
            S_RMW_RD: begin
                ram_addr_o = addr_q;
                state_d    = S_WRITE;
            end
            S_STORE_W, S_WRITE: begin
                // Write strobe comes from registered state only; reset drops it.
                ram_addr_o  = addr_q;
                ram_wdata_o = merge_q;
                ram_wr_en_o = we_q && !rst;
                state_d     = S_IDLE;
            end
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= ZERO_WORD;
            wdata_q    <= ZERO_WORD;
            merge_q    <= ZERO_WORD;
            size_q     <= LSU_SIZE_B;
            we_q       <= 1'b0;
            unsigned_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= ZERO_WORD;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                addr_q     <= bus.addr_i;
                wdata_q    <= bus.wdata_i;
                size_q     <= lsu_size_e'(bus.size_i);
                we_q       <= bus.we_i;
                unsigned_q <= bus.unsigned_i;
                // Word stores write this directly; sub-word stores overwrite it in RMW_RD.
                merge_q    <= bus.wdata_i;
            end
            case (state_q)
                S_ERR: begin
                    done_q  <= 1'b1;
                    err_q   <= 1'b1;
                    rdata_q <= ZERO_WORD;
                end
                S_LOAD: begin
                    done_q  <= 1'b1;
                    err_q   <= 1'b0;
                    rdata_q <= load_data;
                end
                S_RMW_RD: merge_q <= merge_data;
                S_STORE_W, S_WRITE: begin
                    done_q  <= 1'b1;
                    err_q   <= 1'b0;
                    rdata_q <= ZERO_WORD;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_lsu_ctrl.sv
// Directed bench for ram_lsu_ctrl with a behavioural word RAM.
module tb_ram_lsu_ctrl;

    localparam int unsigned DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b1;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic        ram_wr_en;

    logic [31:0] mem [DEPTH];
    int          wr_cnt  = 0;
    logic [31:0] wr_addr = '0;
    logic        bd_we   = 1'b0;
    logic [7:0]  bd_idx  = '0;
    logic [31:0] bd_data = '0;

    int n_checks = 0;
    int n_errors = 0;

    ram_lsu_ctrl_if bus ();

    ram_lsu_ctrl #(.RAM_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .ram_addr_o  (ram_addr),
        .ram_wdata_o (ram_wdata),
        .ram_wr_en_o (ram_wr_en),
        .ram_rdata_i (ram_rdata)
    );

    always #5 clk = ~clk;

    assign ram_rdata = (ram_addr[31:2] < 30'(DEPTH)) ? mem[ram_addr[9:2]] : '0;

    always @(posedge clk) begin
        if (clr) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[8'(i)] <= '0;
        end else if (ram_wr_en) begin
            mem[ram_addr[9:2]] <= ram_wdata;
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= ram_addr;
        end else if (bd_we) begin
            mem[bd_idx] <= bd_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [7:0] idx, input logic [31:0] d);
        @(negedge clk);
        bd_we = 1'b1; bd_idx = idx; bd_data = d;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    // Issue one access; lat counts edges from the accepting edge to done_o high.
    task automatic do_op(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output logic err, output logic [31:0] rd);
        int guard;
        @(negedge clk);
        bus.req_i = 1'b1; bus.we_i = we; bus.size_i = sz;
        bus.unsigned_i = uns; bus.addr_i = a; bus.wdata_i = wd;
        guard = 0;
        while (!bus.ready_o && guard < 20) begin @(negedge clk); guard++; end
        if (!bus.ready_o) check("accept_timeout", 32'(bus.ready_o), 32'd1);
        @(posedge clk);
        #1 bus.req_i = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!bus.done_o && lat < 10) begin @(negedge clk); lat++; end
        if (!bus.done_o) check("done_timeout", 32'(bus.done_o), 32'd1);
        err = bus.err_o;
        rd  = bus.rdata_o;
    endtask

    task automatic set_op(input int k);
        bus.unsigned_i = 1'b0;
        case (k)
            0: begin bus.we_i = 1'b1; bus.size_i = 2'b10; bus.addr_i = 32'h10; bus.wdata_i = 32'hDEADBEEF; end
            1: begin bus.we_i = 1'b0; bus.size_i = 2'b00; bus.addr_i = 32'h11; bus.wdata_i = '0; bus.unsigned_i = 1'b1; end
            2: begin bus.we_i = 1'b1; bus.size_i = 2'b01; bus.addr_i = 32'h12; bus.wdata_i = 32'h00001234; end
            default: begin bus.we_i = 1'b0; bus.size_i = 2'b10; bus.addr_i = 32'h10; bus.wdata_i = '0; end
        endcase
    endtask

    initial begin
        int          lat, w0, k, n_done, cyc;
        logic        err, dn, acc;
        logic [31:0] rd;
        logic        b2b_load [4];
        logic [31:0] b2b_exp  [4];
        b2b_load = '{1'b0, 1'b1, 1'b0, 1'b1};
        b2b_exp  = '{32'h0, 32'h000000BE, 32'h0, 32'h1234BEEF};

        bus.req_i = 1'b0; bus.we_i = 1'b0; bus.size_i = 2'b00;
        bus.unsigned_i = 1'b0; bus.addr_i = '0; bus.wdata_i = '0;

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus.ready_o), 32'd0);
        check("rst_done",  32'(bus.done_o),  32'd0);
        check("rst_err",   32'(bus.err_o),   32'd0);
        check("rst_rdata", bus.rdata_o,      32'h0);
        check("rst_wr_en", 32'(ram_wr_en),   32'd0);
        check("rst_addr",  ram_addr,         32'h0);
        check("rst_wdata", ram_wdata,        32'h0);
        clr = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(bus.ready_o), 32'd1);

        // Word store then word load
        w0 = wr_cnt;
        do_op(1'b1, 2'b10, 1'b0, 32'h8, 32'h11223344, lat, err, rd);
        check("stw_lat", 32'(lat), 32'd2);
        check("stw_err", 32'(err), 32'd0);
        check("stw_wr_cnt", 32'(wr_cnt - w0), 32'd1);
        check("stw_wr_addr", wr_addr, 32'h8);
        check("stw_mem", mem[2], 32'h11223344);
        @(negedge clk);
        check("done_one_cycle", 32'(bus.done_o), 32'd0);
        w0 = wr_cnt;
        do_op(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, lat, err, rd);
        check("ldw_lat", 32'(lat), 32'd2);
        check("ldw_data", rd, 32'h11223344);
        check("ldw_err", 32'(err), 32'd0);
        check("ldw_no_wr", 32'(wr_cnt - w0), 32'd0);

        // Sub-word read-modify-write
        poke(8'd1, 32'h11223344);
        do_op(1'b1, 2'b00, 1'b0, 32'h6, 32'h000000AA, lat, err, rd);
        check("stb_lat", 32'(lat), 32'd3);
        check("stb_mem", mem[1], 32'h11AA3344);
        do_op(1'b1, 2'b01, 1'b0, 32'h4, 32'hFFFF8001, lat, err, rd);
        check("sth_lat", 32'(lat), 32'd3);
        check("sth_mem", mem[1], 32'h11AA8001);

        // Extension
        do_op(1'b0, 2'b00, 1'b0, 32'h6, 32'h0, lat, err, rd);
        check("ldb_signed", rd, 32'hFFFFFFAA);
        do_op(1'b0, 2'b00, 1'b1, 32'h6, 32'h0, lat, err, rd);
        check("ldb_unsigned", rd, 32'h000000AA);
        do_op(1'b0, 2'b01, 1'b0, 32'h6, 32'h0, lat, err, rd);
        check("ldh_hi_signed", rd, 32'h000011AA);
        do_op(1'b0, 2'b01, 1'b0, 32'h4, 32'h0, lat, err, rd);
        check("ldh_lo_signed", rd, 32'hFFFF8001);
        do_op(1'b0, 2'b01, 1'b1, 32'h4, 32'h0, lat, err, rd);
        check("ldh_lo_unsigned", rd, 32'h00008001);
        do_op(1'b0, 2'b00, 1'b0, 32'h7, 32'h0, lat, err, rd);
        check("ldb_lane3", rd, 32'h00000011);

        // Rejected accesses
        w0 = wr_cnt;
        do_op(1'b0, 2'b10, 1'b0, 32'h2, 32'h0, lat, err, rd);
        check("err_ldw_mis_err", 32'(err), 32'd1);
        check("err_ldw_mis_lat", 32'(lat), 32'd2);
        check("err_ldw_mis_rdata", rd, 32'h0);
        do_op(1'b1, 2'b01, 1'b0, 32'h5, 32'h0000BEEF, lat, err, rd);
        check("err_sth_mis_err", 32'(err), 32'd1);
        check("err_sth_mis_lat", 32'(lat), 32'd2);
        do_op(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, lat, err, rd);
        check("err_size_err", 32'(err), 32'd1);
        check("err_size_lat", 32'(lat), 32'd2);
        do_op(1'b0, 2'b10, 1'b0, DEPTH * 4, 32'h0, lat, err, rd);
        check("err_range_err", 32'(err), 32'd1);
        check("err_range_lat", 32'(lat), 32'd2);
        do_op(1'b0, 2'b10, 1'b0, DEPTH * 4 - 4, 32'h0, lat, err, rd);
        check("last_word_ok", 32'(err), 32'd0);
        check("err_no_wr", 32'(wr_cnt - w0), 32'd0);
        check("err_mem_kept", mem[1], 32'h11AA8001);

        // Reset during the write cycle of a byte store
        w0 = wr_cnt;
        @(negedge clk);
        bus.req_i = 1'b1; bus.we_i = 1'b1; bus.size_i = 2'b00;
        bus.unsigned_i = 1'b0; bus.addr_i = 32'h5; bus.wdata_i = 32'h55;
        check("rmw_accept_ready", 32'(bus.ready_o), 32'd1);
        @(posedge clk);
        #1 bus.req_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rmw_write_cycle", 32'(ram_wr_en), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_gates_wr_en", 32'(ram_wr_en), 32'd0);
        check("rst_gates_ready", 32'(bus.ready_o), 32'd0);
        @(negedge clk);
        check("rst_no_done", 32'(bus.done_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(bus.ready_o), 32'd1);
        check("post_rst_no_done", 32'(bus.done_o), 32'd0);
        check("rst_mem_kept", mem[1], 32'h11AA8001);
        check("rst_no_wr", 32'(wr_cnt - w0), 32'd0);

        // Back-to-back with req_i held
        w0 = wr_cnt; k = 0; n_done = 0; cyc = 0;
        @(negedge clk);
        set_op(0);
        bus.req_i = 1'b1;
        while (k < 4 && cyc < 40) begin
            if (cyc > 0) @(negedge clk);
            cyc++;
            dn  = bus.done_o;
            acc = bus.ready_o;
            if (dn && n_done < 4) begin
                check("b2b_err", 32'(bus.err_o), 32'd0);
                if (b2b_load[n_done]) check("b2b_rdata", bus.rdata_o, b2b_exp[n_done]);
                n_done++;
            end
            if (acc) begin
                if (k > 0) check("b2b_overlap", 32'(dn), 32'd1);
                @(posedge clk);
                #1;
                k++;
                if (k < 4) set_op(k);
                else       bus.req_i = 1'b0;
            end
        end
        while (n_done < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus.done_o) begin
                check("b2b_err", 32'(bus.err_o), 32'd0);
                if (b2b_load[n_done]) check("b2b_rdata", bus.rdata_o, b2b_exp[n_done]);
                n_done++;
            end
        end
        check("b2b_accepts", 32'(k), 32'd4);
        check("b2b_done_count", 32'(n_done), 32'd4);
        @(negedge clk);
        check("b2b_no_extra_done", 32'(bus.done_o), 32'd0);
        check("b2b_wr_cnt", 32'(wr_cnt - w0), 32'd2);
        check("b2b_mem", mem[4], 32'h1234BEEF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
